// File: rtl/gdiv_pkg.sv
// Shared types and constants for the Goldschmidt divide sequencer.
package gdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_REM   = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } gdiv_state_t;

  localparam int NUM_ITER_DEF = 4;
  localparam int MUL_LAT_DEF  = 1;
  localparam int ITER_W       = $clog2(NUM_ITER_DEF + 1);
  localparam int LAT_W        = (MUL_LAT_DEF > 1) ? $clog2(MUL_LAT_DEF) : 1;

  typedef struct packed {
    logic ld_operands;
    logic stage;
    logic seed_sel;
    logic ld_n;
    logic ld_d;
    logic ld_k;
    logic rem;
    logic ld_rem;
    logic round_en;
    logic ld_q;
    logic bypass;
  } gdiv_ctrl_t;

  function automatic int lat_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/gdiv_ctrl_if.sv
// Handshake and datapath-strobe bundle between fpdiv and the gdiv sequencer.
interface gdiv_ctrl_if import gdiv_pkg::*; #(parameter int IW = ITER_W);

  logic          in_valid;
  logic          in_ready;
  logic          in_special;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic          ld_operands;
  logic          stage;
  logic          seed_sel;
  logic          ld_n;
  logic          ld_d;
  logic          ld_k;
  logic          rem;
  logic          ld_rem;
  logic          round_en;
  logic          ld_q;
  logic          bypass;
  logic [IW-1:0] iter;

  modport slave (
    input  in_valid, in_special, abort, out_ready,
    output in_ready, out_valid, ld_operands, stage, seed_sel, ld_n, ld_d, ld_k,
           rem, ld_rem, round_en, ld_q, bypass, iter
  );

  modport master (
    output in_valid, in_special, abort, out_ready,
    input  in_ready, out_valid, ld_operands, stage, seed_sel, ld_n, ld_d, ld_k,
           rem, ld_rem, round_en, ld_q, bypass, iter
  );

endinterface

// File: rtl/gdiv_phase_timer.sv
// Multiplier-phase down-counter: start loads MUL_LAT-1, last is high on the final cycle.
module gdiv_phase_timer import gdiv_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic last
);

  localparam int LW = lat_width(MUL_LAT);
  localparam logic [LW-1:0] LOAD_VAL = LW'(MUL_LAT - 1);

  logic [LW-1:0] cnt_r;

  // phase countdown, clear wins over start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= LOAD_VAL;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - LW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == '0);

endmodule

// File: rtl/gdiv_ctrl.sv
// Goldschmidt divide sequencer: seed, NUM_ITER N/D refinement pairs, remainder, round, hold result.
module gdiv_ctrl import gdiv_pkg::*; #(
  parameter int NUM_ITER = NUM_ITER_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF
) (
  input logic        clk,
  input logic        reset,
  gdiv_ctrl_if.slave bus
);

  localparam int IW = $clog2(NUM_ITER + 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(NUM_ITER - 1);

  gdiv_state_t   state_r, state_s;
  logic [IW-1:0] iter_r, iter_s;
  logic          stage_r, stage_s;
  logic          special_r, special_s;
  logic          ready_s, accept_s, out_valid_s;
  logic          tmr_start_s, tmr_clear_s, tmr_last_s;
  gdiv_ctrl_t    strb_s;

  gdiv_phase_timer #(.MUL_LAT(MUL_LAT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear_s),
    .start (tmr_start_s),
    .last  (tmr_last_s)
  );

  // state, iteration index, phase and special-operand registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      iter_r    <= '0;
      stage_r   <= 1'b0;
      special_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      iter_r    <= iter_s;
      stage_r   <= stage_s;
      special_r <= special_s;
    end
  end

  // next-state and Moore strobe decode; abort overrides everything
  always_comb begin
    state_s     = state_r;
    iter_s      = iter_r;
    stage_s     = stage_r;
    special_s   = special_r;
    tmr_start_s = 1'b0;
    tmr_clear_s = 1'b0;
    out_valid_s = 1'b0;
    strb_s      = '0;
    ready_s     = ((state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready)) && !bus.abort;
    accept_s    = ready_s && bus.in_valid;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s   = ST_LOAD;
          special_s = bus.in_special;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        strb_s.ld_operands = 1'b1;
        strb_s.seed_sel    = 1'b1;
        if (special_r) begin
          state_s = ST_DONE;
        end else begin
          state_s     = ST_ITER;
          iter_s      = '0;
          stage_s     = 1'b0;
          tmr_start_s = 1'b1;
        end
      end
      ST_ITER: begin
        strb_s.stage    = stage_r;
        strb_s.seed_sel = (iter_r == '0) && !stage_r;
        if (tmr_last_s) begin
          tmr_start_s = 1'b1;
          if (!stage_r) begin
            strb_s.ld_n = 1'b1;
            stage_s     = 1'b1;
          end else begin
            strb_s.ld_d = 1'b1;
            strb_s.ld_k = 1'b1;
            stage_s     = 1'b0;
            if (iter_r == ITER_LAST) begin
              state_s = ST_REM;
              iter_s  = '0;
            end else begin
              iter_s = iter_r + IW'(1);
            end
          end
        end else begin
          stage_s = stage_r;
        end
      end
      ST_REM: begin
        strb_s.rem = 1'b1;
        if (tmr_last_s) begin
          strb_s.ld_rem = 1'b1;
          state_s       = ST_ROUND;
        end else begin
          state_s = ST_REM;
        end
      end
      ST_ROUND: begin
        strb_s.round_en = 1'b1;
        strb_s.ld_q     = 1'b1;
        state_s         = ST_DONE;
      end
      ST_DONE: begin
        out_valid_s   = 1'b1;
        strb_s.bypass = special_r;
        if (accept_s) begin
          state_s   = ST_LOAD;
          special_s = bus.in_special;
        end else if (bus.out_ready) begin
          state_s   = ST_IDLE;
          special_s = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_s     = ST_IDLE;
      iter_s      = '0;
      stage_s     = 1'b0;
      special_s   = 1'b0;
      tmr_start_s = 1'b0;
      tmr_clear_s = 1'b1;
      out_valid_s = 1'b0;
      strb_s      = '0;
    end else begin
      tmr_clear_s = (state_s == ST_IDLE);
    end
  end

  assign bus.in_ready    = ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.ld_operands = strb_s.ld_operands;
  assign bus.stage       = strb_s.stage;
  assign bus.seed_sel    = strb_s.seed_sel;
  assign bus.ld_n        = strb_s.ld_n;
  assign bus.ld_d        = strb_s.ld_d;
  assign bus.ld_k        = strb_s.ld_k;
  assign bus.rem         = strb_s.rem;
  assign bus.ld_rem      = strb_s.ld_rem;
  assign bus.round_en    = strb_s.round_en;
  assign bus.ld_q        = strb_s.ld_q;
  assign bus.bypass      = strb_s.bypass;
  assign bus.iter        = iter_r;

endmodule
